// File: rtl/execute_alu_mux_stage.sv
// Execute-stage result mux with a two-entry skid buffer.
// Selects the ALU/shift/compare result and hands it downstream with its tag.
module execute_alu_mux_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [DATA_WIDTH:0]   d_gmath,
   input  logic [DATA_WIDTH-1:0] d_shift,
   input  logic [2:0]            sel,
   input  logic [TAG_WIDTH-1:0]  i_tag,
   input  logic                  flush,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [TAG_WIDTH-1:0]  o_tag
);

   localparam int W = DATA_WIDTH;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         main_data_q, main_data_d;
   logic [TAG_WIDTH-1:0] main_tag_q, main_tag_d;
   logic [W-1:0]         skid_data_q, skid_data_d;
   logic [TAG_WIDTH-1:0] skid_tag_q, skid_tag_d;

   logic [W-1:0] sel_res;
   logic         gm_zero;
   logic         accept;
   logic         deliver;

   assign gm_zero = (d_gmath[W-1:0] == '0);

   always_comb begin
      sel_res = d_gmath[W-1:0];
      case (sel)
         3'b001:  sel_res = d_shift;
         3'b010:  sel_res = {{(W-1){1'b0}}, d_gmath[W-1]};
         3'b011:  sel_res = {{(W-1){1'b0}}, d_gmath[W]};
         3'b100:  sel_res = {{(W-1){1'b0}}, gm_zero};
         3'b101:  sel_res = {{(W-1){1'b0}}, !gm_zero};
         default: sel_res = d_gmath[W-1:0];
      endcase
   end

   // i_ready depends on state only, never on o_ready
   assign i_ready = (state_q != S_TWO);
   assign o_valid = (state_q != S_EMPTY);
   assign o_data  = main_data_q;
   assign o_tag   = main_tag_q;

   assign accept  = i_valid && i_ready;
   assign deliver = o_valid && o_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_tag_d  = main_tag_q;
      skid_data_d = skid_data_q;
      skid_tag_d  = skid_tag_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_data_d = sel_res;
                  main_tag_d  = i_tag;
                  state_d     = S_ONE;
               end
            end
            S_ONE: begin
               if (accept && deliver) begin
                  main_data_d = sel_res;
                  main_tag_d  = i_tag;
               end else if (accept) begin
                  skid_data_d = sel_res;
                  skid_tag_d  = i_tag;
                  state_d     = S_TWO;
               end else if (deliver) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               if (deliver) begin
                  main_data_d = skid_data_q;
                  main_tag_d  = skid_tag_q;
                  state_d     = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_EMPTY;
         main_data_q <= '0;
         main_tag_q  <= '0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_tag_q  <= main_tag_d;
         skid_data_q <= skid_data_d;
         skid_tag_q  <= skid_tag_d;
      end
   end

endmodule
